seg_scan_ctrl: RTL

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. It stores a 4-digit BCD value received over a valid/ready handshake and presents one digit at a time on `bcd` to the per-digit BCD-to-segment decoder, while driving the active-low anode enables. New values take effect only at a frame boundary, so no partially updated number is ever shown. Optional leading-zero blanking and an inter-digit guard interval suppress ghosting.

---
 rtl/seg_scan_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan controller.
// Frame-aligned value updates, leading-zero blanking and an anode guard interval.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic        lz_blank,
  output logic [3:0]  bcd,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW:0]   GUARD = (CW+1)'(GUARD_CYC);

  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   shown, shown_n;
  logic [15:0]   pend;
  logic          pend_v, pend_v_n;
  logic          tick, frame, xfer, lead;
  logic [3:0]    nib, an_n, bcd_n;

  assign in_ready = !pend_v;
  assign xfer     = in_valid && in_ready;
  assign tick     = (cnt == LAST);
  assign frame    = tick && (idx == 2'd3);

  always_comb begin
    cnt_n    = tick ? '0 : cnt + CW'(1);
    idx_n    = tick ? idx + 2'd1 : idx;
    shown_n  = shown;
    pend_v_n = pend_v;
    if (frame && pend_v) begin
      shown_n  = pend;
      pend_v_n = 1'b0;
    end
    // a transfer needs pend_v=0, so it never competes with the swap above
    if (xfer) pend_v_n = 1'b1;
  end

  // pins are computed from next-state so they line up with the new cnt/idx
  always_comb begin
    nib  = shown_n[{idx_n, 2'b00} +: 4];
    lead = 1'b0;
    unique case (idx_n)
      2'd1:    lead = (shown_n[15:4] == 12'h000);
      2'd2:    lead = (shown_n[15:8] == 8'h00);
      2'd3:    lead = (shown_n[15:12] == 4'h0);
      default: lead = 1'b0;
    endcase
    bcd_n = (lz_blank && lead) ? 4'hF : nib;
    an_n  = ({1'b0, cnt_n} < GUARD) ? 4'b1111
                                    : ~(4'b0001 << idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shown  <= 16'h0000;
      pend   <= 16'h0000;
      pend_v <= 1'b0;
      an     <= 4'b1111;
      bcd    <= 4'hF;
    end else begin
      cnt    <= cnt_n;
      idx    <= idx_n;
      shown  <= shown_n;
      pend_v <= pend_v_n;
      if (xfer) pend <= in_value;
      an     <= an_n;
      bcd    <= bcd_n;
    end
  end

endmodule
